// File: rtl/prga_io_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : prga_io_seq_monitor
// Purpose  : Ordered I/O sequence checker. Walks a loaded table of masked
//            expected values as each appears stably on io_in.
// Revision : 1.0 - initial release
// ============================================================================
module prga_io_seq_monitor #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int STABLE = 1,
    parameter int TW     = 16,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_value,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             start,
    input  logic [TW-1:0]    timeout_cycles,
    input  logic [WIDTH-1:0] io_in,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [WIDTH-1:0] fail_value,
    output logic [SW-1:0]    step
);

    localparam int         c_idx_w        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         c_stb_w        = $clog2(STABLE + 1);
    localparam logic [1:0] c_code_none    = 2'b00;
    localparam logic [1:0] c_code_timeout = 2'b01;
    localparam logic [1:0] c_code_empty   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_value [DEPTH];
    logic [WIDTH-1:0]   r_mask  [DEPTH];
    logic [SW-1:0]      r_count;
    logic [SW-1:0]      r_step;
    logic [WIDTH-1:0]   r_sample;
    logic [c_stb_w-1:0] r_stable;
    logic [TW-1:0]      r_timer;
    logic [1:0]         r_fail_code;
    logic [WIDTH-1:0]   r_fail_value;

    logic               w_wr_accept;
    logic [SW-1:0]      w_count_eff;
    logic               w_start_empty;
    logic [c_idx_w-1:0] w_cur_idx;
    logic               w_match;
    logic [c_stb_w-1:0] w_stable_inc;
    logic               w_advance;
    logic               w_last;
    logic               w_expire;

    assign wr_ready      = (r_state == S_IDLE) && (r_count < SW'(DEPTH)) && !clear;
    assign w_wr_accept   = wr_valid && wr_ready;
    // A write landing in the start cycle counts towards the empty-table check.
    assign w_count_eff   = r_count + SW'(w_wr_accept);
    assign w_start_empty = (w_count_eff == '0);

    assign w_cur_idx    = r_step[c_idx_w-1:0];
    assign w_match      = ((r_sample ^ r_value[w_cur_idx]) & r_mask[w_cur_idx]) == '0;
    assign w_stable_inc = r_stable + c_stb_w'(1);
    assign w_advance    = (r_state == S_ARMED) && w_match && (w_stable_inc == c_stb_w'(STABLE));
    assign w_last       = (r_step == r_count - SW'(1));
    // Step completion outranks a timeout expiring on the same edge.
    assign w_expire     = (r_state == S_ARMED) && (timeout_cycles != '0) &&
                          (r_timer == timeout_cycles - TW'(1)) && !w_advance;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = w_start_empty ? S_FAIL : S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_advance && w_last) begin
                        w_state_next = S_PASS;
                    end else if (w_expire) begin
                        w_state_next = S_FAIL;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sample <= '0;
        end else begin
            r_sample <= io_in;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            r_value[r_count[c_idx_w-1:0]] <= wr_value;
            r_mask[r_count[c_idx_w-1:0]]  <= wr_mask;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_count      <= '0;
            r_step       <= '0;
            r_stable     <= '0;
            r_timer      <= '0;
            r_fail_code  <= c_code_none;
            r_fail_value <= '0;
        end else if (clear) begin
            r_count      <= '0;
            r_step       <= '0;
            r_stable     <= '0;
            r_timer      <= '0;
            r_fail_code  <= c_code_none;
            r_fail_value <= '0;
        end else begin
            if (w_wr_accept) begin
                r_count <= r_count + SW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_step   <= '0;
                        r_stable <= '0;
                        r_timer  <= '0;
                        if (w_start_empty) begin
                            r_fail_code  <= c_code_empty;
                            r_fail_value <= r_sample;
                        end
                    end
                end
                S_ARMED: begin
                    if (w_advance) begin
                        r_step   <= r_step + SW'(1);
                        r_stable <= '0;
                        r_timer  <= '0;
                    end else begin
                        r_stable <= w_match ? w_stable_inc : '0;
                        r_timer  <= r_timer + TW'(1);
                    end
                    if (w_expire) begin
                        r_fail_code  <= c_code_timeout;
                        r_fail_value <= r_sample;
                    end
                end
                default: begin
                    r_step <= r_step;
                end
            endcase
        end
    end

    assign busy       = (r_state == S_ARMED);
    assign pass       = (r_state == S_PASS);
    assign fail       = (r_state == S_FAIL);
    assign fail_code  = r_fail_code;
    assign fail_value = r_fail_value;
    assign step       = r_step;

endmodule
`default_nettype wire

// File: tb/tb_prga_io_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_prga_io_seq_monitor
// Purpose  : Self-checking bench; two monitors (STABLE=1 and STABLE=2) share
//            stimulus and are compared against a sequence-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prga_io_seq_monitor;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int TW      = 16;
    localparam int SW      = 5;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_PASS  = 2;
    localparam int M_FAIL  = 3;

    logic             clock = 1'b0;
    logic             resetb = 1'b0;
    logic             clear = 1'b0;
    logic             wr_valid = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] wr_value = '0;
    logic [WIDTH-1:0] wr_mask = '0;
    logic [WIDTH-1:0] io_in = '0;
    logic [TW-1:0]    timeout_cycles = '0;

    logic             wr_ready_0, busy_0, pass_0, fail_0;
    logic [1:0]       code_0;
    logic [WIDTH-1:0] fval_0;
    logic [SW-1:0]    step_0;
    logic             wr_ready_1, busy_1, pass_1, fail_1;
    logic [1:0]       code_1;
    logic [WIDTH-1:0] fval_1;
    logic [SW-1:0]    step_1;

    int n_tests = 0;
    int n_fail  = 0;

    int               m_mode  [2];
    int               m_cnt   [2];
    int               m_step  [2];
    int               m_run   [2];
    int               m_since [2];
    logic [1:0]       m_code  [2];
    logic [WIDTH-1:0] m_fval  [2];
    logic [WIDTH-1:0] m_samp  [2];
    logic [WIDTH-1:0] m_val   [2][DEPTH];
    logic [WIDTH-1:0] m_msk   [2][DEPTH];
    logic [WIDTH-1:0] ev [DEPTH];
    logic [WIDTH-1:0] em [DEPTH];

    always #5 clock = ~clock;

    prga_io_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(1), .TW(TW)) u_dut_s1 (
        .clock(clock), .resetb(resetb), .clear(clear), .wr_valid(wr_valid),
        .wr_ready(wr_ready_0), .wr_value(wr_value), .wr_mask(wr_mask), .start(start),
        .timeout_cycles(timeout_cycles), .io_in(io_in), .busy(busy_0), .pass(pass_0),
        .fail(fail_0), .fail_code(code_0), .fail_value(fval_0), .step(step_0)
    );

    prga_io_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(2), .TW(TW)) u_dut_s2 (
        .clock(clock), .resetb(resetb), .clear(clear), .wr_valid(wr_valid),
        .wr_ready(wr_ready_1), .wr_value(wr_value), .wr_mask(wr_mask), .start(start),
        .timeout_cycles(timeout_cycles), .io_in(io_in), .busy(busy_1), .pass(pass_1),
        .fail(fail_1), .fail_code(code_1), .fail_value(fval_1), .step(step_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = M_IDLE;
            m_cnt[k]   = 0;
            m_step[k]  = 0;
            m_run[k]   = 0;
            m_since[k] = 0;
            m_code[k]  = 2'b00;
            m_fval[k]  = '0;
            m_samp[k]  = '0;
        end
    endtask

    // One clock edge of the reference: k selects the monitor (needed run = k+1).
    task automatic model_edge(input int k);
        int               need = k + 1;
        logic [WIDTH-1:0] s    = m_samp[k];
        bit take = wr_valid && !clear && (m_mode[k] == M_IDLE) && (m_cnt[k] < DEPTH);
        if (clear) begin
            m_mode[k] = M_IDLE;
            m_cnt[k]  = 0;
            m_step[k] = 0;
            m_code[k] = 2'b00;
        end else begin
            if (take) begin
                m_val[k][m_cnt[k]] = wr_value;
                m_msk[k][m_cnt[k]] = wr_mask;
                m_cnt[k]++;
            end
            if (m_mode[k] == M_IDLE && start) begin
                if (m_cnt[k] == 0) begin
                    m_mode[k] = M_FAIL;
                    m_code[k] = 2'b10;
                    m_fval[k] = s;
                end else begin
                    m_mode[k]  = M_ARMED;
                    m_step[k]  = 0;
                    m_run[k]   = 0;
                    m_since[k] = 0;
                end
            end else if (m_mode[k] == M_ARMED) begin
                if (((s ^ m_val[k][m_step[k]]) & m_msk[k][m_step[k]]) == '0) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == need) begin
                    m_step[k]++;
                    m_run[k]   = 0;
                    m_since[k] = 0;
                    if (m_step[k] == m_cnt[k]) m_mode[k] = M_PASS;
                end else begin
                    m_since[k]++;
                    if (timeout_cycles != '0 && m_since[k] == int'(timeout_cycles)) begin
                        m_mode[k] = M_FAIL;
                        m_code[k] = 2'b01;
                        m_fval[k] = s;
                    end
                end
            end
        end
        m_samp[k] = io_in;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic             o_busy  = (k == 0) ? busy_0 : busy_1;
            logic             o_pass  = (k == 0) ? pass_0 : pass_1;
            logic             o_fail  = (k == 0) ? fail_0 : fail_1;
            logic             o_rdy   = (k == 0) ? wr_ready_0 : wr_ready_1;
            logic [1:0]       o_code  = (k == 0) ? code_0 : code_1;
            logic [WIDTH-1:0] o_fval  = (k == 0) ? fval_0 : fval_1;
            logic [SW-1:0]    o_step  = (k == 0) ? step_0 : step_1;
            chk($sformatf("d%0d_busy", k), o_busy, m_mode[k] == M_ARMED);
            chk($sformatf("d%0d_pass", k), o_pass, m_mode[k] == M_PASS);
            chk($sformatf("d%0d_fail", k), o_fail, m_mode[k] == M_FAIL);
            chk($sformatf("d%0d_fail_code", k), o_code, m_code[k]);
            chk($sformatf("d%0d_step", k), o_step, m_step[k]);
            chk($sformatf("d%0d_wr_ready", k), o_rdy,
                (m_mode[k] == M_IDLE) && (m_cnt[k] < DEPTH) && !clear);
            if (m_mode[k] == M_FAIL) chk($sformatf("d%0d_fail_value", k), o_fval, m_fval[k]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!resetb) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic [WIDTH-1:0] v, input int n);
        io_in = v;
        repeat (n) tick();
    endtask

    task automatic write_entry(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] m);
        wr_valid = 1'b1;
        wr_value = v;
        wr_mask  = m;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] vals [12];
        int               n;
        logic [WIDTH-1:0] r8;

        model_reset();
        tick();
        tick();
        resetb = 1'b1;
        chk("reset_step", step_0, 0);
        chk("reset_wr_ready", wr_ready_0, 1);
        chk("reset_fail_value", fval_0, 0);

        // Twelve fixed entries, each held 3 cycles with 0x55 gaps.
        vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
        io_in = 8'h55;
        timeout_cycles = '0;
        for (int i = 0; i < 12; i++) write_entry(vals[i], 8'hFF);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            io_in = vals[i];
            tick();
            tick();
            chk("t1_advance_two_edges", step_0, i + 1);
            tick();
            drive(8'h55, 1);
        end
        drive(8'h55, 2);
        chk("t1_pass", pass_0, 1);
        chk("t1_step", step_0, 12);
        chk("t1_fail", fail_0, 0);
        chk("t1_pass_s2", pass_1, 1);

        // STABLE=2: single-cycle pulse does not count, two-cycle hold does.
        do_clear();
        write_entry(8'h3C, 8'hFF);
        write_entry(8'h99, 8'hFF);
        io_in = 8'h00;
        pulse_start();
        drive(8'h3C, 1);
        drive(8'h00, 3);
        chk("t2_pulse_no_advance", step_1, 0);
        drive(8'h3C, 1);
        chk("t2_k", step_1, 0);
        tick();
        chk("t2_k1", step_1, 0);
        tick();
        chk("t2_k2", step_1, 1);

        // Timeout of 50 cycles after step 0 completes.
        do_clear();
        timeout_cycles = 16'd50;
        write_entry(8'h22, 8'hFF);
        write_entry(8'hA5, 8'hFF);
        io_in = 8'h11;
        pulse_start();
        drive(8'h22, 2);
        chk("t3_step0_done", step_0, 1);
        drive(8'h11, 49);
        chk("t3_no_fail_yet", fail_0, 0);
        tick();
        chk("t3_fail", fail_0, 1);
        chk("t3_code", code_0, 2'b01);
        chk("t3_value", fval_0, 8'h11);
        chk("t3_step", step_0, 1);
        tick();
        chk("t3_fail_s2", fail_1, 1);

        // Completion on the expiry edge wins.
        do_clear();
        timeout_cycles = 16'd5;
        write_entry(8'h40, 8'hFF);
        write_entry(8'h41, 8'hFF);
        io_in = 8'h00;
        pulse_start();
        drive(8'h00, 3);
        drive(8'h40, 2);
        chk("t3b_advance", step_0, 1);
        chk("t3b_no_fail", fail_0, 0);
        chk("t3b_s2_timeout", code_1, 2'b01);

        // Masked compare on bit 7 only.
        do_clear();
        timeout_cycles = '0;
        write_entry(8'h80, 8'h80);
        write_entry(8'h00, 8'hFF);
        pulse_start();
        drive(8'h7F, 4);
        chk("t4_no_match", step_0, 0);
        drive(8'hFF, 3);
        chk("t4_match", step_0, 1);

        // Empty-table start, then fill to capacity.
        do_clear();
        drive(8'h5A, 2);
        pulse_start();
        chk("t5_empty_fail", fail_0, 1);
        chk("t5_empty_code", code_0, 2'b10);
        chk("t5_empty_value", fval_0, 8'h5A);
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ev[i] = 8'($urandom);
            em[i] = 8'($urandom) | 8'h01;
            write_entry(ev[i], em[i]);
        end
        chk("t5_full_not_ready", wr_ready_0, 0);
        write_entry(8'hEE, 8'hFF);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            r8 = 8'($urandom);
            drive(ev[i] ^ (r8 & ~em[i]), 3);
            drive(8'($urandom), 1);
        end
        drive(8'h00, 2);
        chk("t5_pass", pass_0, 1);
        chk("t5_step16", step_0, 16);
        chk("t5_step16_s2", step_1, 16);

        // Clear mid-ARMED at step 3, then asynchronous reset mid-ARMED.
        do_clear();
        for (int i = 0; i < 6; i++) write_entry(8'(8'h10 + i), 8'hFF);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'h10 + i), 3);
            drive(8'h00, 1);
        end
        chk("t6_at_step3", step_0, 3);
        do_clear();
        #1;
        chk("t6_clear_busy", busy_0, 0);
        chk("t6_clear_step", step_0, 0);
        chk("t6_clear_ready", wr_ready_0, 1);
        write_entry(8'h20, 8'hFF);
        write_entry(8'h21, 8'hFF);
        pulse_start();
        drive(8'h20, 3);
        chk("t6_armed", busy_0, 1);
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_busy", busy_0, 0);
        chk("t6_rst_step", step_0, 0);
        chk("t6_rst_ready", wr_ready_1, 1);
        #1;
        resetb = 1'b1;
        tick();

        // Randomised sequences with optional timeouts.
        for (int r = 0; r < 6; r++) begin
            do_clear();
            n = $urandom_range(1, 6);
            timeout_cycles = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(4, 30)) : 16'd0;
            for (int i = 0; i < n; i++) begin
                ev[i] = 8'($urandom);
                em[i] = 8'($urandom);
                write_entry(ev[i], em[i]);
            end
            pulse_start();
            for (int i = 0; i < n; i++) begin
                drive(8'($urandom), $urandom_range(0, 2));
                r8 = 8'($urandom);
                drive(ev[i] ^ (r8 & ~em[i]), $urandom_range(1, 4));
            end
            drive(8'($urandom), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
